cmp_filter_unit: RTL and testbench
==================================

# cmp_filter_unit

Parametrised, registered four-mode magnitude/equality comparator with a consecutive-cycle glitch filter on its result. A single-cycle `mode_tick` pulse, typically from the debouncer on a board button, cycles the comparison mode. Board-level test tops instantiate it between the switch inputs and an LED. It replaces the fixed 8-bit two-mode comparator pair with one configurable block.

## Interface
Parameters:
- `WIDTH`, 8: operand width in bits, ≥ 2.
- `HOLD`, 4: consecutive cycles a new raw result must persist before `out` follows, ≥ 1.

Ports:
- `clk` in 1: system clock; all state on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `a` in WIDTH: operand A.
- `b` in WIDTH: operand B.
- `mode_tick` in 1: one-cycle pulse; advances mode.
- `mode` out 2: current comparison mode.
- `raw` out 1: registered, unfiltered comparison result.
- `out` out 1: filtered comparison result.
- `change_tick` out 1: one-cycle pulse when `out` changes.

## Operation
- Modes, selected by `mode`:
  - 0: unsigned a > b.
  - 1: signed (two's complement) a > b.
  - 2: a == b.
  - 3: signed a < b.
- Mode register:
  - Advances mode+1 mod 4 on each cycle with `mode_tick`=1; 3 wraps to 0.
  - Holding `mode_tick` high for N cycles advances N times.
- Raw stage: each edge, `raw` <= cmp(a, b, current `mode` register value before any update this edge).
- Filter, with internal counter `cnt` of width clog2(HOLD)+1:
  - If `mode_tick`: `cnt` <= 0, `out` held. `mode_tick` takes priority over every filter action.
  - Else if `raw` == `out`: `cnt` <= 0.
  - Else if `cnt` == HOLD-1: `out` <= `raw`, `cnt` <= 0, `change_tick` <= 1.
  - Else: `cnt` <= `cnt`+1.
- `change_tick` is 0 in every cycle not listed above.
- A raw disagreement shorter than HOLD cycles never reaches `out`. Counting restarts from 0 after any agreement.
- Reset: `mode`=0, `raw`=0, `out`=0, `cnt`=0, `change_tick`=0. Reset overrides `mode_tick` and filter activity. Reset mid-count discards the count.

## Timing
- `a`/`b` sampled at edge E0; `raw` valid after E0.
- `out` and `change_tick` update at edge E0+HOLD at the earliest, provided `raw` ≠ `out` at each of edges E0+1 … E0+HOLD.
- HOLD=1: `out` follows `raw` one edge later.
- Mode change at edge M: `raw` reflects the new mode after edge M+1. Filtering restarts, so `out` settles by edge M+1+HOLD.
- `mode_tick` at the edge where `cnt` would reach HOLD-1: no update; count cleared.
- `change_tick` width is exactly one cycle. Minimum spacing between pulses is HOLD cycles.

## Configuration
- `CMP_STICKY_EN` defined:
  - Adds input `clr` (1) and output `sticky` (1).
  - `sticky` sets on the edge where `out` changes 0→1.
  - `sticky` clears on `clr`=1 or reset; `clr` wins over simultaneous set.
  - `sticky` resets to 0; its value is unchanged by mode changes.
- `CMP_STICKY_EN` not defined: `clr`/`sticky` ports and logic absent; all other behaviour identical.

## Test plan
- Reset with `a`=0xFF, `b`=0x00, `mode_tick`=1 held: all outputs 0, `mode`=0 throughout reset. After release with `mode_tick`=0: `raw`=1 after one edge, `out`=1 four edges later, single `change_tick` pulse.
- WIDTH=8, HOLD=4, mode 0, `a`=0x80, `b`=0x01: `out`=1. One `mode_tick` → mode 1: `raw`=0 next edge (−128 < 1). `out`=0 four edges after that, one `change_tick`.
- Glitch: from steady `out`=0, drive `a`>`b` for 3 cycles then back: `out` stays 0, no `change_tick`. Repeat with 4 cycles: `out`=1 at edge E0+4.
- Mode wrap: four `mode_tick` pulses from mode 0 → `mode` sequence 1,2,3,0. Mode 2 with `a`=`b`=0x5A → `out`=1. Mode 3 with `a`=0xFE, `b`=0x01 → `out`=1.
- Priority: pulse `mode_tick` on the edge `cnt` would reach 3 → `out` unchanged that edge, count restarts. HOLD=1 build: `out` tracks `raw` with one-edge lag.
- With `CMP_STICKY_EN` defined: `out` 0→1 sets `sticky`. `out` returning to 0 leaves `sticky`=1. `clr` coincident with a new rise → `sticky`=0.

Source files
------------

// File: rtl/cmp_filter_unit.sv
// cmp_filter_unit: four-mode registered comparator (unsigned >, signed >, ==, signed <) with glitch filter.
// Latency: raw one edge after a/b are sampled; out follows HOLD edges after raw first disagrees with it.
// No backpressure: inputs are sampled every cycle. Optional build macro CMP_STICKY_EN adds clr/sticky.
module cmp_filter_unit #(
    parameter int WIDTH = 8,
    parameter int HOLD  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode_tick,
`ifdef CMP_STICKY_EN
    input  logic             clr,
    output logic             sticky,
`endif
    output logic [1:0]       mode,
    output logic             raw,
    output logic             out,
    output logic             change_tick
);

    // Counter is wide enough to hold HOLD-1 for every legal HOLD (HOLD=1 gives one bit).
    localparam int CW = $clog2(HOLD) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(HOLD - 1);

    typedef enum logic [1:0] {
        MODE_UGT = 2'd0,
        MODE_SGT = 2'd1,
        MODE_EQ  = 2'd2,
        MODE_SLT = 2'd3
    } mode_e;

    mode_e          mode_q, mode_d;
    logic           raw_q, raw_d;
    logic           out_q, out_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           chg_q, chg_d;
    logic           rise;

    // Comparison uses the mode register as it stands before this edge's tick.
    always_comb begin
        raw_d = 1'b0;
        unique case (mode_q)
            MODE_UGT: raw_d = (a > b);
            MODE_SGT: raw_d = ($signed(a) > $signed(b));
            MODE_EQ:  raw_d = (a == b);
            MODE_SLT: raw_d = ($signed(a) < $signed(b));
            default:  raw_d = 1'b0;
        endcase
    end

    // Mode advances once per cycle that mode_tick is high; 3 wraps to 0 naturally.
    always_comb begin
        mode_d = mode_q;
        if (mode_tick) begin
            mode_d = mode_e'(mode_q + 2'd1);
        end
    end

    // Filter: a tick clears the count and freezes out, agreement clears the count,
    // otherwise count disagreeing cycles and commit raw on the HOLD-th one.
    always_comb begin
        out_d = out_q;
        cnt_d = cnt_q;
        chg_d = 1'b0;
        rise  = 1'b0;
        if (mode_tick) begin
            cnt_d = '0;
        end else if (raw_q == out_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            out_d = raw_q;
            cnt_d = '0;
            chg_d = 1'b1;
            rise  = raw_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // All state registers with synchronous reset; reset dominates tick and filter.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q <= MODE_UGT;
            raw_q  <= 1'b0;
            out_q  <= 1'b0;
            cnt_q  <= '0;
            chg_q  <= 1'b0;
        end else begin
            mode_q <= mode_d;
            raw_q  <= raw_d;
            out_q  <= out_d;
            cnt_q  <= cnt_d;
            chg_q  <= chg_d;
        end
    end

`ifdef CMP_STICKY_EN
    logic sticky_q, sticky_d;

    // Sticky latches any 0->1 transition of out; clr takes precedence over a same-cycle set.
    always_comb begin
        sticky_d = sticky_q;
        if (clr) begin
            sticky_d = 1'b0;
        end else if (rise) begin
            sticky_d = 1'b1;
        end
    end

    // Sticky register; untouched by mode changes.
    always_ff @(posedge clk) begin
        if (reset) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign sticky = sticky_q;
`else
    logic unused_rise;
    assign unused_rise = rise;
`endif

    assign mode        = mode_q;
    assign raw         = raw_q;
    assign out         = out_q;
    assign change_tick = chg_q;

endmodule

// File: tb/tb_cmp_filter_unit.sv
// Directed bench for cmp_filter_unit: HOLD=4 main instance plus a HOLD=1 instance on shared inputs.
// Inputs change 1 time unit after a rising edge; outputs are checked at the same point.
// Sticky checks are compiled in only when CMP_STICKY_EN is defined.
module tb_cmp_filter_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] a;
    logic [7:0] b;
    logic       mode_tick;
    logic [1:0] mode4, mode1;
    logic       raw4, raw1;
    logic       out4, out1;
    logic       chg4, chg1;
`ifdef CMP_STICKY_EN
    logic       clr;
    logic       sticky4, sticky1;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cmp_filter_unit #(.WIDTH(8), .HOLD(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .a           (a),
        .b           (b),
        .mode_tick   (mode_tick),
`ifdef CMP_STICKY_EN
        .clr         (clr),
        .sticky      (sticky4),
`endif
        .mode        (mode4),
        .raw         (raw4),
        .out         (out4),
        .change_tick (chg4)
    );

    cmp_filter_unit #(.WIDTH(8), .HOLD(1)) dut_h1 (
        .clk         (clk),
        .reset       (reset),
        .a           (a),
        .b           (b),
        .mode_tick   (mode_tick),
`ifdef CMP_STICKY_EN
        .clr         (clr),
        .sticky      (sticky1),
`endif
        .mode        (mode1),
        .raw         (raw1),
        .out         (out1),
        .change_tick (chg1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one rising edge and settle just past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic stepn(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        reset     = 1'b1;
        a         = 8'hFF;
        b         = 8'h00;
        mode_tick = 1'b1;
`ifdef CMP_STICKY_EN
        clr       = 1'b0;
`endif
        // Reset with tick held: everything stays zero.
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_mode", mode4, 0);
            check("rst_raw", raw4, 0);
            check("rst_out", out4, 0);
            check("rst_chg", chg4, 0);
        end
`ifdef CMP_STICKY_EN
        check("rst_sticky", sticky4, 0);
`endif
        reset     = 1'b0;
        mode_tick = 1'b0;

        // Release: raw after one edge, out four edges later with a single pulse.
        step();
        check("rel_raw", raw4, 1);
        check("rel_out0", out4, 0);
        check("h1_rel_raw", raw1, 1);
        check("h1_rel_out0", out1, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("rel_out", out4, (i == 3) ? 1 : 0);
            check("rel_chg", chg4, (i == 3) ? 1 : 0);
            if (i == 0) begin
                check("h1_rel_out", out1, 1);
                check("h1_rel_chg", chg1, 1);
            end
        end
        step();
        check("rel_chg_clear", chg4, 0);
        check("rel_out_hold", out4, 1);
`ifdef CMP_STICKY_EN
        check("sticky_set", sticky4, 1);
`endif

        // Signed vs unsigned: 0x80 > 0x01 unsigned, -128 < 1 signed.
        a = 8'h80;
        b = 8'h01;
        stepn(3);
        check("m0_raw", raw4, 1);
        check("m0_out", out4, 1);
        mode_tick = 1'b1;
        step();
        mode_tick = 1'b0;
        check("m1_mode", mode4, 1);
        check("m1_out_hold", out4, 1);
        step();
        check("m1_raw", raw4, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("m1_out", out4, (i == 3) ? 0 : 1);
            check("m1_chg", chg4, (i == 3) ? 1 : 0);
        end
`ifdef CMP_STICKY_EN
        check("sticky_keep", sticky4, 1);
`endif

        // Glitch of 3 cycles in mode 1 (0x10 > 0x01): filtered away.
        a = 8'h00;
        b = 8'h00;
        stepn(3);
        check("gl_pre_out", out4, 0);
        a = 8'h10;
        b = 8'h01;
        for (int i = 0; i < 6; i++) begin
            step();
            if (i == 2) a = 8'h00;
            check("gl3_out", out4, 0);
            check("gl3_chg", chg4, 0);
            check("h1_gl3_out", out1, (i >= 1 && i < 4) ? 1 : 0);
        end
        // Same disturbance lasting 4 cycles: out rises at E0+4.
        a = 8'h10;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin
`ifdef CMP_STICKY_EN
                clr = 1'b1;
`endif
            end
            step();
            if (i == 3) a = 8'h00;
            check("gl4_out", out4, (i == 4) ? 1 : 0);
            check("gl4_chg", chg4, (i == 4) ? 1 : 0);
        end
`ifdef CMP_STICKY_EN
        check("sticky_clr_wins", sticky4, 0);
        clr = 1'b0;
        step();
        check("sticky_stays_clr", sticky4, 0);
`endif
        stepn(6);
        check("gl4_settle", out4, 0);

        // Mode wrap: hold tick 3 cycles from mode 1 to reach 0, then four single pulses.
        mode_tick = 1'b1;
        stepn(3);
        mode_tick = 1'b0;
        check("wrap_base", mode4, 0);
        for (int i = 0; i < 4; i++) begin
            mode_tick = 1'b1;
            step();
            mode_tick = 1'b0;
            check("wrap_mode", mode4, (i + 1) % 4);
            check("h1_wrap_mode", mode1, (i + 1) % 4);
            step();
        end

        // Mode 2 equality.
        a = 8'h5A;
        b = 8'h5A;
        mode_tick = 1'b1;
        stepn(2);
        mode_tick = 1'b0;
        check("eq_mode", mode4, 2);
        stepn(6);
        check("eq_out", out4, 1);

        // Mode 3 signed less-than: 0x5A==0x5A gives 0, then -2 < 1 gives 1.
        mode_tick = 1'b1;
        step();
        mode_tick = 1'b0;
        check("lt_mode", mode4, 3);
        stepn(6);
        check("lt_out0", out4, 0);
        a = 8'hFE;
        b = 8'h01;
        stepn(4);
        check("lt_out_pre", out4, 0);
        step();
        check("lt_out", out4, 1);
        check("lt_chg", chg4, 1);

        // Tick on the edge cnt would reach 3: no update, count restarts.
        a = 8'h5A;
        b = 8'h5A;
        for (int i = 1; i <= 8; i++) begin
            if (i == 4) mode_tick = 1'b1;
            step();
            mode_tick = 1'b0;
            check("pri_out", out4, (i == 8) ? 0 : 1);
            check("pri_chg", chg4, (i == 8) ? 1 : 0);
        end
        check("pri_mode", mode4, 0);

        // Reset mid-count discards progress.
        a = 8'h10;
        b = 8'h01;
        stepn(3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_out", out4, 0);
        check("midrst_raw", raw4, 0);
        stepn(4);
        check("midrst_hold", out4, 0);
        step();
        check("midrst_rise", out4, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
